// File: rtl/layer1_pool_pkg.sv
// rtl/layer1_pool_pkg.sv - shared geometry, pixel width and FSM encoding for layer1_pool
package layer1_pool_pkg;

    localparam int IMG_DIM = 8;
    localparam int OUT_DIM = IMG_DIM / 2;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pool_max2.sv
// rtl/pool_max2.sv - signed two-input maximum
module pool_max2 #(
    parameter int DATA_W = layer1_pool_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] max_o
);

    assign max_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;

endmodule

// File: rtl/layer1_pool.sv
// rtl/layer1_pool.sv - streaming 2x2 max-pool into a 4x4 buffer; LAYER1_POOL_RELU_EN clamps negatives to 0
module layer1_pool #(
    parameter int IMG_DIM = layer1_pool_pkg::IMG_DIM,
    parameter int DATA_W  = layer1_pool_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              we,
    output logic [1:0]        i,
    output logic [1:0]        j,
    output logic [DATA_W-1:0] dataout,
    output logic              busy,
    output logic              done
);

    import layer1_pool_pkg::*;

    localparam int LB_N = IMG_DIM / 2;
    localparam int CW   = $clog2(IMG_DIM);

    state_t            state_q, state_d;
    logic [CW-1:0]     r_q, r_d, c_q, c_d;
    logic [DATA_W-1:0] pair_q, pair_d;
    logic [DATA_W-1:0] line_q [LB_N];
    logic [DATA_W-1:0] line_d [LB_N];
    logic              we_q, we_d;
    logic [1:0]        i_q, i_d, j_q, j_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] pair_max, win_max, win_res;
    logic              accept, last_px;

    assign in_ready = (state_q == ST_RUN);
    assign accept   = in_valid & in_ready;
    assign last_px  = (r_q == CW'(IMG_DIM - 1)) && (c_q == CW'(IMG_DIM - 1));

    // pair_q holds the even-column pixel, so on odd columns this is the pair max
    pool_max2 #(.DATA_W(DATA_W)) u_pair (
        .a_i   (pair_q),
        .b_i   (in_data),
        .max_o (pair_max)
    );

    pool_max2 #(.DATA_W(DATA_W)) u_win (
        .a_i   (line_q[c_q[CW-1:1]]),
        .b_i   (pair_max),
        .max_o (win_max)
    );

`ifdef LAYER1_POOL_RELU_EN
    assign win_res = win_max[DATA_W-1] ? '0 : win_max;
`else
    assign win_res = win_max;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (accept && last_px) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        r_d    = r_q;
        c_d    = c_q;
        pair_d = pair_q;
        line_d = line_q;
        we_d   = 1'b0;
        i_d    = i_q;
        j_d    = j_q;
        dout_d = dout_q;
        if (state_q == ST_IDLE && start) begin
            r_d = '0;
            c_d = '0;
        end
        if (accept) begin
            if (c_q == CW'(IMG_DIM - 1)) begin
                c_d = '0;
                r_d = r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
            pair_d = c_q[0] ? pair_max : in_data;
            if (c_q[0]) begin
                if (!r_q[0]) begin
                    line_d[c_q[CW-1:1]] = pair_max;
                end else begin
                    we_d   = 1'b1;
                    i_d    = 2'(r_q >> 1);
                    j_d    = 2'(c_q >> 1);
                    dout_d = win_res;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            pair_q  <= '0;
            for (int k = 0; k < LB_N; k++) line_q[k] <= '0;
            we_q    <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            pair_q  <= pair_d;
            line_q  <= line_d;
            we_q    <= we_d;
            i_q     <= i_d;
            j_q     <= j_d;
            dout_q  <= dout_d;
        end
    end

    assign we      = we_q;
    assign i       = i_q;
    assign j       = j_q;
    assign dataout = dout_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_layer1_pool.sv
// tb/tb_layer1_pool.sv - self-checking bench for layer1_pool (honours LAYER1_POOL_RELU_EN)
module tb_layer1_pool;

    localparam int N    = 8;
    localparam int NPIX = N * N;

`ifdef LAYER1_POOL_RELU_EN
    localparam logic [7:0] NEG_HI = 8'h00;
    localparam logic [7:0] NEG_LO = 8'h00;
`else
    localparam logic [7:0] NEG_HI = 8'hFF;
    localparam logic [7:0] NEG_LO = 8'h80;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, we, busy, done;
    logic [1:0] i, j;
    logic [7:0] dataout;

    layer1_pool #(.IMG_DIM(N), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .we       (we),
        .i        (i),
        .j        (j),
        .dataout  (dataout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         a;
        int         b;
        logic [7:0] d;
        int         cyc;
    } wr_t;

    typedef struct {
        int         kind;
        int         mode;
        int         a;
        int         b;
        logic [7:0] exp;
    } vec_t;

    wr_t        wq[$];
    int         done_cyc[$];
    int         acc_cyc[$];
    bit         mon_en = 1'b0;
    logic [7:0] pix   [NPIX];
    logic [7:0] exp_v [16];
    int         checks = 0;
    int         failures = 0;
    vec_t       tbl [7];

    always @(negedge clk) begin
        if (mon_en) begin
            if (we) wq.push_back(wr_t'{int'(i), int'(j), dataout, cyc});
            if (done) done_cyc.push_back(cyc);
            if (in_valid && in_ready && !rst) acc_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: each output is the signed maximum of its 2x2 input window
    task automatic model();
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                int m;
                m = -1000;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++) begin
                        int v;
                        v = int'($signed(pix[(2*a+dr)*N + 2*b+dc]));
                        if (v > m) m = v;
                    end
`ifdef LAYER1_POOL_RELU_EN
                if (m < 0) m = 0;
`endif
                exp_v[a*4+b] = 8'(m);
            end
        end
    endtask

    task automatic fill(input int kind);
        for (int k = 0; k < NPIX; k++) begin
            case (kind)
                0:       pix[k] = 8'(k);
                1:       pix[k] = 8'h80;
                default: pix[k] = 8'($urandom_range(0, 255));
            endcase
        end
        if (kind == 1) pix[2*N+5] = 8'hFF;
    endtask

    task automatic begin_frame();
        wq.delete();
        done_cyc.delete();
        acc_cyc.delete();
        mon_en = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic feed(input int mode, input int start_at, input int abort_at);
        int idx;
        int guard;
        bit acc;
        idx = 0;
        guard = 0;
        while (idx < NPIX && guard < 2000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (guard % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = pix[idx];
            start = (idx == start_at) && in_valid;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) idx++;
            if (abort_at >= 0 && idx == abort_at) break;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (abort_at < 0) chk("feed_count", idx, NPIX);
    endtask

    task automatic finish_frame();
        int g;
        g = 0;
        while (busy && g < 10) begin
            @(posedge clk); #1;
            g++;
        end
        chk("idle_after_frame", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
    endtask

    task automatic check_frame();
        model();
        chk("write_count", wq.size(), 16);
        chk("accept_count", acc_cyc.size(), NPIX);
        for (int k = 0; k < wq.size() && k < 16; k++) begin
            int a, b;
            a = k / 4;
            b = k % 4;
            chk($sformatf("wr%0d_i", k), wq[k].a, a);
            chk($sformatf("wr%0d_j", k), wq[k].b, b);
            chk($sformatf("wr%0d_data", k), int'(wq[k].d), int'(exp_v[k]));
            if (acc_cyc.size() == NPIX)
                chk($sformatf("wr%0d_latency", k), wq[k].cyc, acc_cyc[(2*a+1)*N + 2*b+1] + 1);
        end
        chk("done_pulses", done_cyc.size(), 1);
        if (done_cyc.size() >= 1 && wq.size() == 16)
            chk("done_with_last_write", done_cyc[0], wq[15].cyc);
    endtask

    function automatic int find_wr(input int a, input int b);
        for (int k = 0; k < wq.size(); k++)
            if (wq[k].a == a && wq[k].b == b) return int'(wq[k].d);
        return -1;
    endfunction

    task automatic run_frame(input int kind, input int mode, input int start_at);
        fill(kind);
        begin_frame();
        feed(mode, start_at, -1);
        finish_frame();
        check_frame();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 0, 0, 0, 8'd9};
        tbl[1] = '{0, 0, 3, 3, 8'd63};
        tbl[2] = '{0, 1, 1, 2, 8'd29};
        tbl[3] = '{0, 1, 2, 1, 8'd43};
        tbl[4] = '{1, 0, 1, 2, NEG_HI};
        tbl[5] = '{1, 0, 0, 0, NEG_LO};
        tbl[6] = '{1, 1, 3, 3, NEG_LO};

        // Reset holds everything at zero even with start and valid asserted
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_we", int'(we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_i", int'(i), 0);
        chk("rst_j", int'(j), 0);
        chk("rst_dataout", int'(dataout), 0);
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++) begin
            run_frame(tbl[t].kind, tbl[t].mode, -1);
            chk($sformatf("tbl%0d_value", t), find_wr(tbl[t].a, tbl[t].b), int'(tbl[t].exp));
        end

        for (int t = 0; t < 3; t++) run_frame(2, 2, -1);

        // Start pulsed mid-frame must not disturb the frame
        run_frame(0, 0, 30);

        // Reset after 20 accepted pixels discards the frame
        fill(0);
        begin_frame();
        feed(0, -1, 20);
        chk("abort_writes_before_rst", wq.size(), 4);
        rst = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("midrst_we", int'(we), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        in_valid = 1'b0;
        mon_en = 1'b0;
        @(posedge clk); #1;
        run_frame(0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layer1_pool.md
LAYER1_POOL -- requirements
Module: layer1_pool

Interface
REQ-001 SHALL have parameter IMG_DIM, default 8: input feature-map side length in pixels.
REQ-002 SHALL have parameter DATA_W, default 8: pixel width, signed two's complement.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: begin a frame; honoured only in IDLE.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data carries a pixel.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a pixel this cycle.
REQ-008 SHALL have port in_data, input, DATA_W bits: pixel, row-major order.
REQ-009 SHALL have port we, output, 1 bit: write strobe to the 4x4 layer-2 buffer.
REQ-010 SHALL have port i, output, 2 bits: buffer row index.
REQ-011 SHALL have port j, output, 2 bits: buffer column index.
REQ-012 SHALL have port dataout, output, DATA_W bits: pooled value.
REQ-013 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-015 SHALL run FSM IDLE -> RUN on start, RUN -> DONE on acceptance of pixel IMG_DIM*IMG_DIM, DONE -> IDLE unconditionally.
REQ-016 SHALL assert in_ready only in RUN; a pixel is accepted when in_valid and in_ready are both 1.
REQ-017 SHALL track row r and column c of each accepted pixel; c wraps IMG_DIM-1 -> 0 and increments r.
REQ-018 SHALL hold pixel max(even c, odd c) in a column-pair register and, on even rows, store it into line buffer entry c>>1.
REQ-019 SHALL, on odd r and odd c, form signed max(line buffer entry c>>1, current pair max) as the 2x2 window result.
REQ-020 SHALL register the window result: we=1, i=r>>1, j=c>>1, dataout=result exactly one cycle after the window's 4th pixel is accepted; we=0 otherwise.
REQ-021 SHALL hold i, j and dataout at their last written values while we=0.
REQ-022 SHALL assert done in the cycle of the final write (i=3, j=3); buffer contents are complete from the following cycle.
REQ-023 SHALL ignore start outside IDLE; start coincident with done SHALL be ignored.
REQ-024 SHALL issue no writes and advance no counters on cycles with no accepted pixel (bubbles allowed).

Reset
REQ-025 SHALL, with rst=1, force state IDLE; r, c, line buffer, and pair register to 0; outputs in_ready, we, i, j, dataout, busy, done to 0.
REQ-026 SHALL let rst override all other inputs, including mid-frame; a frame interrupted by reset is discarded and no pending write is issued.

Configuration
REQ-027 SHALL, when macro LAYER1_POOL_RELU_EN is defined, output max(result, 0) (negative window results become 0x00).
REQ-028 SHALL, when LAYER1_POOL_RELU_EN is undefined, output the raw signed window maximum.

Structure
REQ-029 SHALL place IMG_DIM, OUT_DIM (=IMG_DIM/2), DATA_W and the FSM state encoding in shared package layer1_pool_pkg.
REQ-030 SHALL implement the signed two-input maximum in sub-module pool_max2, instantiated for the pair max and the window max.

Verification
REQ-031 SHALL cover the reset case: rst high for 2 cycles -> in_ready=we=busy=done=0, i=j=0, dataout=0.
REQ-032 SHALL cover a ramp frame: start, then pixels 0..63 on consecutive cycles -> 16 writes, value at (a,b) = 16a+2b+9, e.g. (0,0)=9, (3,3)=63; done pulses once, coincident with the (3,3) write.
REQ-033 SHALL cover a negative frame: all pixels 0x80 except pixel (2,5)=0xFF -> (1,2)=0xFF, others 0x80 without the macro; with LAYER1_POOL_RELU_EN all 16 writes = 0x00.
REQ-034 SHALL cover bubbles: the ramp frame with in_valid on alternate cycles -> identical 16 (i, j, dataout) writes, each exactly 1 cycle after its window's 4th acceptance.
REQ-035 SHALL cover reset mid-frame: rst after 20 accepted pixels -> we=0 and in_ready=0 next cycle; a fresh start plus ramp then yields the full REQ-032 result.
REQ-036 SHALL cover start ignored while busy: start pulsed at pixel 30 -> counters unaffected and the frame completes normally.
